// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential, handshaked ALU sitting between issue and writeback.
//
// Single-cycle ops produce a registered result one cycle after acceptance.
// With ALU_MUL_EN defined, opcode 11 (MUL) runs an iterative shift-and-add
// multiplier and back-pressures issue through in_ready while it works.
// Without ALU_MUL_EN, opcode 11 behaves like the other unused opcodes
// (result 0, carry 0, one-cycle latency).
//
// Parameters:
//   N   operand/result width (power of two, >= 2)
//   SW  shift-amount width, taken from op_b[SW-1:0]
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation presented by issue
//   in_ready   block accepts an operation this cycle
//   opcode     operation select (0..15)
//   op_a/op_b  operands, sampled only at acceptance
//   out_valid  result and flags are valid
//   out_ready  writeback takes the result
//   out        registered result
//   carry      ADD carry-out / SUB borrow, 0 otherwise
//   zero       high when out == 0
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         carry,
  output logic         zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state, state_next, start_state;

  logic [N-1:0] out_r;
  logic         carry_r;
  logic         accept;
  logic [N:0]   alu_res;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;
  // Count must reach N (one extra BUSY cycle registers the accumulator).
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  acc;
  logic [CW-1:0] count;
  logic          is_mul;
  logic          mul_last;

  assign is_mul      = (opcode == OP_MUL);
  assign mul_last    = (count == CW'(N));
  assign start_state = is_mul ? BUSY : DONE;
`else
  assign start_state = DONE;
`endif

  // Single-cycle datapath: bit N carries the ADD carry-out / SUB borrow,
  // forced to 0 for every other opcode.
  function automatic logic [N:0] alu_op(input logic [3:0]   opc,
                                        input logic [N-1:0] a,
                                        input logic [N-1:0] b);
    logic [N:0]    r;
    logic [N-1:0]  sra;
    logic [SW-1:0] sh;
    sh  = b[SW-1:0];
    sra = $signed(a) >>> sh;
    case (opc)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {{N{1'b0}}, (a < b)};
      4'd3:    r = {{N{1'b0}}, (a == b)};
      4'd4:    r = {1'b0, a | b};
      4'd5:    r = {1'b0, a & b};
      4'd6:    r = {1'b0, ~a};
      4'd7:    r = {1'b0, a ^ b};
      4'd8:    r = {1'b0, a << sh};
      4'd9:    r = {1'b0, a >> sh};
      4'd10:   r = {1'b0, sra};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_res = alu_op(opcode, op_a, op_b);
  assign accept  = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; DONE chains straight into a new op when both
  // handshakes fire, so back-to-back single-cycle ops have no bubble.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = start_state;
`ifdef ALU_MUL_EN
      BUSY: if (mul_last) state_next = DONE;
`endif
      DONE: if (out_ready) state_next = in_valid ? start_state : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend only on state and out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Result/flag registers and, when enabled, the shift-and-add multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r   <= '0;
      carry_r <= 1'b0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_MUL_EN
      if (is_mul) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        count  <= '0;
      end else begin
        out_r   <= alu_res[N-1:0];
        carry_r <= alu_res[N];
      end
`else
      out_r   <= alu_res[N-1:0];
      carry_r <= alu_res[N];
`endif
    end
`ifdef ALU_MUL_EN
    else if (state == BUSY) begin
      if (mul_last) begin
        out_r   <= acc;
        carry_r <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
    end
`endif
  end

  assign out   = out_r;
  assign carry = carry_r;
  assign zero  = (out_r == '0);

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (N = 32).
// Directed table of single-cycle vectors, hand-written back-pressure and
// reset sequences, MUL timing when ALU_MUL_EN is defined, then randomized
// traffic checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int N  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out;
  logic          carry;
  logic          zero;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_c;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        c;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  // Overall time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Reference model written from the opcode rules with plain arithmetic.
  function automatic res_t ref_alu(input logic [3:0] opc, input logic [31:0] a,
                                   input logic [31:0] b);
    res_t        res;
    logic [63:0] wide;
    int          sh;
    sh    = int'(b & 32'h1F);
    res.r = 32'h0;
    res.c = 1'b0;
    case (opc)
      4'd0: begin wide = 64'(a) + 64'(b); res.r = wide[31:0]; res.c = wide[32]; end
      4'd1: begin res.r = a - b; res.c = (a < b); end
      4'd2: res.r = (a < b) ? 32'd1 : 32'd0;
      4'd3: res.r = (a == b) ? 32'd1 : 32'd0;
      4'd4: res.r = a | b;
      4'd5: res.r = a & b;
      4'd6: res.r = ~a;
      4'd7: res.r = a ^ b;
      4'd8: res.r = a << sh;
      4'd9: res.r = a >> sh;
      4'd10: res.r = 32'($signed(a) >>> sh);
`ifdef ALU_MUL_EN
      4'd11: begin wide = 64'(a) * 64'(b); res.r = wide[31:0]; end
`endif
      default: res.r = 32'h0;
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [3:0] opc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic ordy);
    in_valid  = iv;
    opcode    = opc;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e;
    res_t held;
    logic hold;
    int   seen;

    // ---------------- reset ----------------
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    repeat (2) tick();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out", out, 32'h0);
    checkOutput("reset zero", 32'(zero), 32'd1);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // ---------------- directed table ----------------
    vecs.push_back('{"add wrap",  4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
    vecs.push_back('{"sub borrow",4'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b1});
    vecs.push_back('{"sub plain", 4'd1,  32'd5,        32'd3,        32'h00000002, 1'b0});
    vecs.push_back('{"less t",    4'd2,  32'd3,        32'd5,        32'h00000001, 1'b0});
    vecs.push_back('{"less f",    4'd2,  32'd5,        32'd3,        32'h00000000, 1'b0});
    vecs.push_back('{"eq",        4'd3,  32'd7,        32'd7,        32'h00000001, 1'b0});
    vecs.push_back('{"or",        4'd4,  32'hF0,       32'h0F,       32'h000000FF, 1'b0});
    vecs.push_back('{"and",       4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
    vecs.push_back('{"not",       4'd6,  32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"xor",       4'd7,  32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1'b0});
    vecs.push_back('{"shl 0x21",  4'd8,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0});
    vecs.push_back('{"shr",       4'd9,  32'h80000000, 32'd4,        32'h08000000, 1'b0});
    vecs.push_back('{"sra",       4'd10, 32'h80000000, 32'd4,        32'hF8000000, 1'b0});
    vecs.push_back('{"op12",      4'd12, 32'd7,        32'd6,        32'h00000000, 1'b0});
    vecs.push_back('{"op13",      4'd13, 32'd7,        32'd6,        32'h00000000, 1'b0});
    vecs.push_back('{"op14",      4'd14, 32'd7,        32'd6,        32'h00000000, 1'b0});
    vecs.push_back('{"op15",      4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});
`ifndef ALU_MUL_EN
    vecs.push_back('{"op11 off",  4'd11, 32'd7,        32'd6,        32'h00000000, 1'b0});
`endif

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].opc, vecs[i].a, vecs[i].b, 1'b1);
      #1;
      checkOutput({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
      checkOutput({vecs[i].name, " valid"}, 32'(out_valid), 32'd1);
      checkOutput({vecs[i].name, " out"}, out, vecs[i].exp);
      checkOutput({vecs[i].name, " carry"}, 32'(carry), 32'(vecs[i].exp_c));
      checkOutput({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].exp == 32'h0));
      tick();
    end

    // ---------------- back-pressure, then a queued ADD with no gap --------
    applyStimulus(1'b1, 4'd4, 32'hF0, 32'h0F, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp out", out, 32'h000000FF);
      checkOutput("bp valid", 32'(out_valid), 32'd1);
      checkOutput("bp in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 4'd0, 32'd2, 32'd3, 1'b1);
    #1;
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp release out", out, 32'h000000FF);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("bp second valid", 32'(out_valid), 32'd1);
    checkOutput("bp second out", out, 32'd5);
    tick();
    checkOutput("bp idle valid", 32'(out_valid), 32'd0);

    // ---------------- reset while a result waits in DONE -----------------
    applyStimulus(1'b1, 4'd0, 32'd9, 32'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst done valid", 32'(out_valid), 32'd0);
    checkOutput("rst done out", out, 32'h0);
    checkOutput("rst done in_ready", 32'(in_ready), 32'd1);
    tick();

`ifdef ALU_MUL_EN
    // ---------------- MUL latency and BUSY back-pressure ----------------
    applyStimulus(1'b1, 4'd11, 32'h0000FFFF, 32'h00010001, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    checkOutput("mul busy in_ready", 32'(in_ready), 32'd0);
    checkOutput("mul busy valid", 32'(out_valid), 32'd0);
    for (int i = 1; i <= N; i++) begin
      tick();
      checkOutput($sformatf("mul busy in_ready c%0d", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("mul busy valid c%0d", i), 32'(out_valid), 32'd0);
    end
    tick();
    checkOutput("mul done valid", 32'(out_valid), 32'd1);
    checkOutput("mul done out", out, 32'hFFFFFFFF);
    checkOutput("mul done carry", 32'(carry), 32'd0);
    tick();

    // ---------------- MUL aborted by reset ----------------
    applyStimulus(1'b1, 4'd11, 32'h0000FFFF, 32'h00010001, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mul rst valid", 32'(out_valid), 32'd0);
    checkOutput("mul rst in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("mul rst no result", 32'(seen), 32'd0);
`endif

    // ---------------- randomized traffic vs. reference model -------------
    hold = 1'b0;
    held = '{32'h0, 1'b0};
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk);
      #1;
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    $urandom, $urandom, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) op_b = $urandom_range(0, 40);
      @(negedge clk);
      if (hold) begin
        checkOutput("rand hold valid", 32'(out_valid), 32'd1);
        checkOutput("rand hold out", out, held.r);
        checkOutput("rand hold carry", 32'(carry), 32'(held.c));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rand unexpected result", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rand out", out, e.r);
          checkOutput("rand carry", 32'(carry), 32'(e.c));
          checkOutput("rand zero", 32'(zero), 32'(e.r == 32'h0));
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_alu(opcode, op_a, op_b));
      hold   = out_valid && !out_ready;
      held.r = out;
      held.c = carry;
    end

    // Drain whatever is still in flight, with a bounded cycle budget.
    for (int cyc = 0; cyc < 100 && (sb.size() != 0); cyc++) begin
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      if (out_valid && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("drain out", out, e.r);
        checkOutput("drain carry", 32'(carry), 32'(e.c));
      end
    end
    checkOutput("drain empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
